// File: rtl/fpcvt_pkg.sv
// fpcvt_pkg: shared state encoding and format constants for the
// 12-bit sample to S/E3/F4 floating-point converter.
package fpcvt_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ABS   = 3'd1,
    S_SCAN  = 3'd2,
    S_ROUND = 3'd3,
    S_OUT   = 3'd4
  } state_t;

  localparam logic [2:0]  FP_EXP_MAX  = 3'd7;
  localparam logic [3:0]  FP_SIG_MAX  = 4'd15;
  localparam logic [3:0]  FP_SIG_WRAP = 4'd8;
  localparam logic [11:0] SAT_MAG     = 12'h7FF;

endpackage

// File: rtl/significand_extractor.sv
// significand_extractor: picks the 4-bit window d[exp+3:exp]
// and the first bit below it, used as the rounding bit.
module significand_extractor (
  input  logic [11:0] d,
  input  logic [2:0]  exp,
  output logic [3:0]  sig,
  output logic        fifth
);

  logic [3:0] below;

  always_comb begin
    sig   = 4'(d >> exp);
    below = {1'b0, exp} - 4'd1;
    fifth = (exp != 3'd0) && d[below];
  end

endmodule

// File: rtl/fpcvt_sequencer.sv
// fpcvt_sequencer: multi-cycle sample-to-float converter with
// a bit-serial leading-one scan and round-to-nearest-up.
module fpcvt_sequencer
  import fpcvt_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [11:0] in_d,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_s,
  output logic [2:0]  out_e,
  output logic [3:0]  out_f,
  output logic        busy
);

  state_t      state;
  logic [11:0] in_q;
  logic        sign;
  logic [11:0] mag;
  logic [2:0]  exp;

  logic [11:0] mag_abs;
  logic [3:0]  top_idx;
  logic        hit;
  logic [3:0]  sig;
  logic        fifth;
  logic [2:0]  rnd_e;
  logic [3:0]  rnd_f;

  significand_extractor u_sig (
    .d     (mag),
    .exp   (exp),
    .sig   (sig),
    .fifth (fifth)
  );

  // -2048 has no positive twin in 12 bits, so clamp it.
  always_comb begin
    mag_abs = in_q;
    if (in_q == 12'h800)
      mag_abs = SAT_MAG;
    else if (in_q[11])
      mag_abs = 12'd0 - in_q;
  end

  always_comb begin
    top_idx = {1'b0, exp} + 4'd3;
    hit     = mag[top_idx];
  end

  always_comb begin
    rnd_e = exp;
    rnd_f = sig;
    if (fifth) begin
      if (sig != FP_SIG_MAX) begin
        rnd_f = sig + 4'd1;
      end else if (exp != FP_EXP_MAX) begin
        rnd_e = exp + 3'd1;
        rnd_f = FP_SIG_WRAP;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      in_ready  <= 1'b1;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      out_s     <= 1'b0;
      out_e     <= 3'd0;
      out_f     <= 4'd0;
      in_q      <= 12'd0;
      sign      <= 1'b0;
      mag       <= 12'd0;
      exp       <= 3'd0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (in_valid) begin
            in_q     <= in_d;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= S_ABS;
          end
        end
        S_ABS: begin
          sign  <= in_q[11];
          mag   <= mag_abs;
          exp   <= FP_EXP_MAX;
          state <= S_SCAN;
        end
        S_SCAN: begin
          if (exp == 3'd0 || hit)
            state <= S_ROUND;
          else
            exp <= exp - 3'd1;
        end
        S_ROUND: begin
          out_s     <= sign;
          out_e     <= rnd_e;
          out_f     <= rnd_f;
          out_valid <= 1'b1;
          state     <= S_OUT;
        end
        S_OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: begin
          state    <= S_IDLE;
          in_ready <= 1'b1;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fpcvt_sequencer.sv
// tb_fpcvt_sequencer: directed vector table plus stall and
// mid-conversion reset sequences for fpcvt_sequencer.
module tb_fpcvt_sequencer;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] in_d;
  logic        out_valid;
  logic        out_ready;
  logic        out_s;
  logic [2:0]  out_e;
  logic [3:0]  out_f;
  logic        busy;

  int nvec;
  int nfail;

  fpcvt_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_d      (in_d),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_s     (out_s),
    .out_e     (out_e),
    .out_f     (out_f),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] d;
    logic        s;
    int          e;
    int          f;
    int          n;
  } vec_t;

  task automatic check(input string name, input int act,
                       input int want);
    nvec++;
    if (act != want) begin
      nfail++;
      $display("FAIL %s: got %0d want %0d", name, act, want);
    end
  endtask

  // Accept edge, then count edges until out_valid (n+2 edges).
  task automatic run_vec(input vec_t v, input bit hs);
    int cyc;
    cyc = 0;
    check("in_ready_pre", int'(in_ready), 1);
    in_d     = v.d;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    while (!out_valid && cyc < 20) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check("latency", cyc, v.n + 2);
    check("out_s", int'(out_s), int'(v.s));
    check("out_e", int'(out_e), v.e);
    check("out_f", int'(out_f), v.f);
    if (hs) begin
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      check("hs_valid_low", int'(out_valid), 0);
      check("hs_in_ready", int'(in_ready), 1);
    end
  endtask

  vec_t tbl[11];
  vec_t v;

  initial begin
    nvec      = 0;
    nfail     = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_d      = 12'd0;
    out_ready = 1'b0;

    tbl[0]  = '{12'h1A6, 1'b0, 5, 13, 3};
    tbl[1]  = '{12'h07D, 1'b0, 4, 8,  5};
    tbl[2]  = '{12'h800, 1'b1, 7, 15, 1};
    tbl[3]  = '{12'h7FF, 1'b0, 7, 15, 1};
    tbl[4]  = '{12'h000, 1'b0, 0, 0,  8};
    tbl[5]  = '{12'hFFF, 1'b1, 0, 1,  8};
    tbl[6]  = '{12'h010, 1'b0, 1, 8,  7};
    tbl[7]  = '{12'h017, 1'b0, 1, 12, 7};
    tbl[8]  = '{12'hF9C, 1'b1, 3, 13, 5};
    tbl[9]  = '{12'h0F8, 1'b0, 5, 8,  4};
    tbl[10] = '{12'h00F, 1'b0, 0, 15, 8};

    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_out_s", int'(out_s), 0);
    check("rst_out_e", int'(out_e), 0);
    check("rst_out_f", int'(out_f), 0);

    for (int i = 0; i < 11; i++) begin
      run_vec(tbl[i], 1'b1);
      check("idle_busy", int'(busy), 0);
    end

    // Consumer stall with a stray in_valid while in OUT.
    run_vec(tbl[0], 1'b0);
    for (int i = 0; i < 5; i++) begin
      in_d     = 12'h07D;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      check("stall_valid", int'(out_valid), 1);
      check("stall_in_ready", int'(in_ready), 0);
      check("stall_e", int'(out_e), 5);
      check("stall_f", int'(out_f), 13);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("unstall_in_ready", int'(in_ready), 1);
    check("unstall_valid", int'(out_valid), 0);
    check("unstall_busy", int'(busy), 0);

    // Reset while scanning drops the conversion.
    in_d     = 12'h1A6;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("pre_rst_busy", int'(busy), 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("midrst_in_ready", int'(in_ready), 1);
    check("midrst_busy", int'(busy), 0);
    check("midrst_valid", int'(out_valid), 0);
    check("midrst_out_e", int'(out_e), 0);
    check("midrst_out_f", int'(out_f), 0);
    begin
      int seen;
      seen = 0;
      for (int i = 0; i < 12; i++) begin
        @(posedge clk);
        #1;
        if (out_valid) seen++;
      end
      check("no_ghost_result", seen, 0);
    end
    v = tbl[1];
    run_vec(v, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nfail);
    $finish;
  end

endmodule
